distance_text_buffer: RTL and testbench

//   Character-code source for the distance overlay: answers the renderer's char_xy

---
 rtl/distance_text_pkg.sv | 45 ++++
 rtl/distance_text_buffer_bin2bcd_seq.sv | 66 ++++++
 rtl/distance_text_buffer.sv | 147 ++++++++++++++
 tb/tb_distance_text_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/distance_text_pkg.sv
// Shared constants, ASCII codes, FSM encodings and the double-dabble
// adjust helper for the distance overlay text line.
package distance_text_pkg;

    localparam int NUM_CHARS   = 15;
    localparam int DIGIT_FIRST = 6;
    localparam int DIGIT_LAST  = 10;
    localparam int NUM_DIGITS  = 5;
    localparam int BCD_W       = 4 * NUM_DIGITS;

    localparam logic [6:0] ASC_SPACE = 7'h20;
    localparam logic [6:0] ASC_ZERO  = 7'h30;
    localparam logic [6:0] ASC_DASH  = 7'h2D;
    localparam logic [6:0] ASC_D     = 7'h44;
    localparam logic [6:0] ASC_I     = 7'h49;
    localparam logic [6:0] ASC_S     = 7'h53;
    localparam logic [6:0] ASC_T     = 7'h54;
    localparam logic [6:0] ASC_COLON = 7'h3A;
    localparam logic [6:0] ASC_C     = 7'h63;
    localparam logic [6:0] ASC_M     = 7'h6D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // add 3 to every nibble >= 5 ahead of the left shift
    function automatic logic [BCD_W-1:0] dabble_adj(
        input logic [BCD_W-1:0] b
    );
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] digit_ascii(input logic [3:0] d);
        return ASC_ZERO + {3'b000, d};
    endfunction

endpackage

// File: rtl/distance_text_buffer_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, DIST_W shifts,
// then a single DONE cycle in which a new start may be accepted.
module bin2bcd_seq
    import distance_text_pkg::*;
#(
    parameter int DIST_W = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] bin,
    output logic              done,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd
);

    localparam logic [4:0] LAST_IT = 5'(DIST_W - 1);

    conv_state_t       state;
    conv_state_t       state_nxt;
    logic [4:0]        cnt;
    logic [DIST_W-1:0] sh_bin;
    logic [BCD_W-1:0]  sh_bcd;
    logic              load;

    assign load = start && (state != ST_SHIFT);

    always_ff @(posedge pclk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_IT) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (state == ST_DONE);
        busy = (state == ST_SHIFT);
        bcd  = sh_bcd;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt    <= '0;
            sh_bin <= '0;
            sh_bcd <= '0;
        end else if (load) begin
            cnt    <= '0;
            sh_bin <= bin;
            sh_bcd <= '0;
        end else if (state == ST_SHIFT) begin
            cnt              <= cnt + 5'd1;
            {sh_bcd, sh_bin} <= {dabble_adj(sh_bcd), sh_bin} << 1;
        end
    end

endmodule

// File: rtl/distance_text_buffer.sv
// "DIST: ddddd cm " character source with double-buffered BCD digits.
// Optional DIST_LEADING_ZERO_BLANK_EN blanks leading zeros in columns 6-9.
module distance_text_buffer
    import distance_text_pkg::*;
#(
    parameter int DIST_W    = 16,
    parameter int NUM_CHARS = 15,
    parameter int MAX_DIST  = 400
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              dist_valid,
    input  logic              frame_start,
    input  logic [4:0]        char_xy,
    output logic [6:0]        char_code,
    output logic              busy
);

    if (DIST_W > 16) begin : g_dist_w_chk
        $error("distance_text_buffer: DIST_W > 16 is unsupported");
    end

    logic              pend_v;
    logic [DIST_W-1:0] pend_val;
    logic [DIST_W-1:0] sample;
    logic              eng_start;
    logic [DIST_W-1:0] eng_bin;
    logic              eng_done;
    logic              eng_busy;
    logic [BCD_W-1:0]  eng_bcd;
    logic              new_ovr;
    logic [BCD_W-1:0]  staged_bcd;
    logic              staged_ovr;
    logic [BCD_W-1:0]  act_bcd;
    logic              act_ovr;
    logic [6:0]        dig_code [NUM_DIGITS];
    logic [6:0]        code_nxt;

    bin2bcd_seq #(
        .DIST_W (DIST_W)
    ) u_bcd (
        .pclk  (pclk),
        .rst   (rst),
        .start (eng_start),
        .bin   (eng_bin),
        .done  (eng_done),
        .busy  (eng_busy),
        .bcd   (eng_bcd)
    );

    assign busy = eng_busy;

    // a fresh sample in the DONE cycle beats the older pending one
    always_comb begin
        eng_start = (dist_valid && !eng_busy)
                 || (eng_done && pend_v);
        eng_bin   = dist_valid ? dist_in : pend_val;
        new_ovr   = sample > DIST_W'(MAX_DIST);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pend_v   <= 1'b0;
            pend_val <= '0;
        end else if (dist_valid && eng_busy) begin
            pend_v   <= 1'b1;
            pend_val <= dist_in;
        end else if (eng_done) begin
            pend_v   <= 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst)
            sample <= '0;
        else if (eng_start)
            sample <= eng_bin;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            staged_bcd <= '0;
            staged_ovr <= 1'b0;
        end else if (eng_done) begin
            staged_bcd <= eng_bcd;
            staged_ovr <= new_ovr;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            act_bcd <= '0;
            act_ovr <= 1'b0;
        end else if (frame_start) begin
            act_bcd <= eng_done ? eng_bcd : staged_bcd;
            act_ovr <= eng_done ? new_ovr : staged_ovr;
        end
    end

    always_comb begin
        logic       lz;
        logic [3:0] d;
        lz = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d  = act_bcd[(NUM_DIGITS-1-i)*4 +: 4];
            lz = lz && (d == 4'd0);
            if (act_ovr)
                dig_code[i] = ASC_DASH;
`ifdef DIST_LEADING_ZERO_BLANK_EN
            else if (lz && (i < NUM_DIGITS - 1))
                dig_code[i] = ASC_SPACE;
`endif
            else
                dig_code[i] = digit_ascii(d);
        end
    end

    always_comb begin
        code_nxt = ASC_SPACE;
        unique case (char_xy)
            5'd0:    code_nxt = ASC_D;
            5'd1:    code_nxt = ASC_I;
            5'd2:    code_nxt = ASC_S;
            5'd3:    code_nxt = ASC_T;
            5'd4:    code_nxt = ASC_COLON;
            5'd6:    code_nxt = dig_code[0];
            5'd7:    code_nxt = dig_code[1];
            5'd8:    code_nxt = dig_code[2];
            5'd9:    code_nxt = dig_code[3];
            5'd10:   code_nxt = dig_code[4];
            5'd12:   code_nxt = ASC_C;
            5'd13:   code_nxt = ASC_M;
            default: code_nxt = ASC_SPACE;
        endcase
        if (int'(char_xy) >= NUM_CHARS)
            code_nxt = ASC_SPACE;
    end

    always_ff @(posedge pclk) begin
        if (rst)
            char_code <= ASC_SPACE;
        else
            char_code <= code_nxt;
    end

endmodule

// File: tb/tb_distance_text_buffer.sv
// Directed self-checking bench for distance_text_buffer; a second
// instance with MAX_DIST=65535 exercises the full-range bypass case.
module tb_distance_text_buffer;

    logic        pclk;
    logic        rst;
    logic [15:0] dist_in;
    logic        dist_valid;
    logic        frame_start;
    logic [4:0]  char_xy;
    logic [6:0]  char_code;
    logic        busy;
    logic [6:0]  char_code_w;
    logic        busy_w;

    int n_chk;
    int n_fail;

    distance_text_buffer dut (
        .pclk        (pclk),
        .rst         (rst),
        .dist_in     (dist_in),
        .dist_valid  (dist_valid),
        .frame_start (frame_start),
        .char_xy     (char_xy),
        .char_code   (char_code),
        .busy        (busy)
    );

    distance_text_buffer #(
        .MAX_DIST (65535)
    ) dut_w (
        .pclk        (pclk),
        .rst         (rst),
        .dist_in     (dist_in),
        .dist_valid  (dist_valid),
        .frame_start (frame_start),
        .char_xy     (char_xy),
        .char_code   (char_code_w),
        .busy        (busy_w)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_valid(input logic [15:0] v);
        dist_in    = v;
        dist_valid = 1'b1;
        tick();
        dist_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++)
            tick();
        chk(tag, busy, 0);
    endtask

    task automatic lookup(input string tag,
                          input logic [4:0] col,
                          input logic [7:0] exp);
        char_xy = col;
        tick();
        chk(tag, char_code, exp);
    endtask

    task automatic check_digits(input string tag,
                                input string full,
                                input string blanked);
        string s;
`ifdef DIST_LEADING_ZERO_BLANK_EN
        s = blanked;
`else
        s = full;
`endif
        for (int i = 0; i < 5; i++)
            lookup($sformatf("%s_c%0d", tag, i + 6),
                   5'(i + 6), s[i]);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        string line;
        int    cnt;
        int    rises;
        logic  prev;

        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        dist_in     = '0;
        dist_valid  = 1'b0;
        frame_start = 1'b0;
        char_xy     = '0;
        tick();
        tick();
        chk("rst_code", char_code, 7'h20);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

`ifdef DIST_LEADING_ZERO_BLANK_EN
        line = "DIST:     0 cm  ";
`else
        line = "DIST: 00000 cm  ";
`endif
        for (int c = 0; c < 16; c++)
            lookup($sformatf("sweep_c%0d", c), 5'(c), line[c]);
        lookup("col31", 5'd31, 8'h20);

        pulse_valid(16'd123);
        chk("busy_after_valid", busy, 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) cnt++;
            tick();
        end
        chk("busy_cycles", cnt, 16);
        pulse_frame();
        check_digits("d123", "00123", "  123");

        pulse_valid(16'd401);
        wait_idle("idle_401");
        tick();
        pulse_frame();
        check_digits("d401", "-----", "-----");

        pulse_valid(16'd400);
        wait_idle("idle_400");
        tick();
        pulse_frame();
        check_digits("d400", "00400", "  400");

        rises = 0;
        prev  = busy;
        for (int cyc = 0; cyc < 60; cyc++) begin
            dist_valid = (cyc == 0) || (cyc == 3) || (cyc == 5);
            dist_in    = (cyc == 0) ? 16'd250 :
                         (cyc == 3) ? 16'd77  : 16'd99;
            tick();
            dist_valid = 1'b0;
            if (busy && !prev) rises++;
            prev = busy;
        end
        chk("conv_count", rises, 2);
        check_digits("d_unpub", "00400", "  400");
        pulse_frame();
        check_digits("d99", "00099", "   99");

        pulse_valid(16'd65535);
        wait_idle("idle_65535");
        pulse_frame();
        char_xy = 5'd6;
        tick();
        chk("bypass_w_c6", char_code_w, 7'h36);
        chk("bypass_ovr_c6", char_code, 7'h2D);
        char_xy = 5'd10;
        tick();
        chk("bypass_w_c10", char_code_w, 7'h35);

        pulse_valid(16'd321);
        for (int i = 0; i < 8; i++) tick();
        chk("busy_mid", busy, 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_code", char_code, 7'h20);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        pulse_frame();
        check_digits("d_rst", "00000", "    0");
        for (int i = 0; i < 25; i++) tick();
        chk("rst_stay_idle", busy, 0);
        pulse_frame();
        check_digits("d_rst2", "00000", "    0");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
